// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-stage control and program-counter bundle for pc_unit.
// master: the sequencer driving control inputs. slave: the PC unit.
interface pc_unit_if #(
  parameter int PC_W  = 10,
  parameter int TGT_W = 8
);
  logic              start;
  logic [PC_W-1:0]   start_address;
  logic              stall;
  logic              branch;
  logic              taken;
  logic              rel;
  logic [TGT_W-1:0]  target;
  logic              call;
  logic              ret;
  logic [PC_W-1:0]   PC;
  logic              halt;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output start, start_address, stall, branch, taken, rel, target, call, ret,
    input  PC, halt, ras_overflow, ras_underflow
  );

  modport slave (
    input  start, start_address, stall, branch, taken, rel, target, call, ret,
    output PC, halt, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: parametrised fetch-stage program counter with start/stall,
// absolute branches, call/return via an internal return-address stack,
// sticky RAS overflow/underflow flags and a registered halt state.
// Optional build macro PC_BRANCH_REL_EN: taken branches with rel=1 add the
// sign-extended target to PC; when undefined, rel is ignored.
module pc_unit #(
  parameter int PC_W      = 10,
  parameter int TGT_W     = 8,
  parameter int RAS_DEPTH = 4,
  parameter int HALT_ADDR = 63
) (
  input logic     CLK,
  input logic     reset,
  pc_unit_if.slave bus
);

  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_N = 1 << IDX_W;
  localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              halt_q, halt_d;
  logic [PC_W-1:0]   ras_q [RAS_N];

  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   tgt_abs;
  logic [PC_W-1:0]   tgt_branch;

  assign pc_inc   = pc_q + PC_W'(1);
  assign tgt_abs  = PC_W'(bus.target);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

`ifdef PC_BRANCH_REL_EN
  logic signed [TGT_W-1:0] tgt_signed;
  logic [PC_W-1:0]         tgt_rel;
  assign tgt_signed = bus.target;
  assign tgt_rel    = pc_q + PC_W'(tgt_signed);
  assign tgt_branch = bus.rel ? tgt_rel : tgt_abs;
`else
  assign tgt_branch = tgt_abs;
`endif

  // Next-state, next-PC and stack control; start overrides all state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    if (bus.start) begin
      state_d = S_RUN;
      pc_d    = bus.start_address;
      sp_d    = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (!bus.stall) begin
            if (pc_q == HALT_PC) begin
              state_d = S_HALTED;
            end else if (bus.ret) begin
              if (sp_q != '0) begin
                pc_d = ras_q[pop_idx];
                sp_d = sp_q - SP_W'(1);
              end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
              end
            end else if (bus.call) begin
              pc_d = tgt_abs;
              if (sp_q < SP_FULL) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else if (bus.branch && bus.taken) begin
              pc_d = tgt_branch;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        S_HALTED: ;
        default: state_d = S_IDLE;
      endcase
    end

    halt_d = (state_d == S_HALTED);
  end

  // State, PC, stack pointer and flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      halt_q  <= halt_d;
    end
  end

  // Return-address storage; contents are meaningless after reset, so no reset.
  always_ff @(posedge CLK) begin
    if (push_en && !reset) begin
      ras_q[push_idx] <= pc_inc;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.halt          = halt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus randomized checks of pc_unit against a
// queue-based behavioural model; a second small instance covers PC_W=4.
module tb_pc_unit;

  localparam int PC_W  = 10;
  localparam int TGT_W = 8;
  localparam int DEPTH = 4;
  localparam int HADDR = 63;
  localparam int MOD   = 1 << PC_W;

  logic CLK = 1'b0;
  logic reset;
  logic reset4;

  always #5 CLK = ~CLK;

  pc_unit_if #(.PC_W(PC_W), .TGT_W(TGT_W)) bus ();
  pc_unit_if #(.PC_W(4), .TGT_W(4)) bus4 ();

  pc_unit #(.PC_W(PC_W), .TGT_W(TGT_W), .RAS_DEPTH(DEPTH), .HALT_ADDR(HADDR)) dut (
    .CLK(CLK), .reset(reset), .bus(bus)
  );

  pc_unit #(.PC_W(4), .TGT_W(4), .RAS_DEPTH(2), .HALT_ADDR(15)) dut4 (
    .CLK(CLK), .reset(reset4), .bus(bus4)
  );

  // Behavioural model: PC as integer, RAS as a queue.
  int m_pc;
  bit m_run, m_halt, m_ovf, m_unf;
  int m_ras[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sext(input int t);
    return (t >= (1 << (TGT_W - 1))) ? t - (1 << TGT_W) : t;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_run = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
      m_ras.delete();
    end else if (bus.start) begin
      m_pc = int'(bus.start_address); m_run = 1; m_halt = 0; m_ovf = 0; m_unf = 0;
      m_ras.delete();
    end else if (m_run && !bus.stall) begin
      if (m_pc == HADDR) begin
        m_run = 0; m_halt = 1;
      end else if (bus.ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = (m_pc + 1) % MOD; m_unf = 1; end
      end else if (bus.call) begin
        if (m_ras.size() < DEPTH) m_ras.push_back((m_pc + 1) % MOD);
        else m_ovf = 1;
        m_pc = int'(bus.target);
      end else if (bus.branch && bus.taken) begin
`ifdef PC_BRANCH_REL_EN
        if (bus.rel) m_pc = (m_pc + sext(int'(bus.target)) + MOD) % MOD;
        else m_pc = int'(bus.target);
`else
        m_pc = int'(bus.target);
`endif
      end else begin
        m_pc = (m_pc + 1) % MOD;
      end
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check({tag, ".pc"},   32'(bus.PC),            32'(m_pc));
    check({tag, ".halt"}, 32'(bus.halt),          32'(m_halt));
    check({tag, ".ovf"},  32'(bus.ras_overflow),  32'(m_ovf));
    check({tag, ".unf"},  32'(bus.ras_underflow), 32'(m_unf));
  endtask

  task automatic idle();
    bus.start = 0; bus.start_address = '0; bus.stall = 0; bus.branch = 0;
    bus.taken = 0; bus.rel = 0; bus.target = '0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic idle4();
    bus4.start = 0; bus4.start_address = '0; bus4.stall = 0; bus4.branch = 0;
    bus4.taken = 0; bus4.rel = 0; bus4.target = '0; bus4.call = 0; bus4.ret = 0;
  endtask

  task automatic do_start(input int sa);
    idle(); bus.start = 1; bus.start_address = PC_W'(sa);
    cyc("start");
    idle();
  endtask

  initial begin
    idle(); idle4();
    reset = 1; reset4 = 1;
    cyc("reset");
    check("reset_pc", 32'(bus.PC), 32'd0);
    reset = 0; reset4 = 0;
    cyc("idle_hold");

    // Count from 10 up to the halt address, then halt one cycle later.
    do_start(10);
    check("start10_pc", 32'(bus.PC), 32'd10);
    repeat (53) cyc("count");
    check("reach63_pc", 32'(bus.PC), 32'd63);
    check("reach63_halt", 32'(bus.halt), 32'd0);
    cyc("halt_enter");
    check("halted", 32'(bus.halt), 32'd1);
    repeat (5) cyc("halted_hold");
    check("halted_pc", 32'(bus.PC), 32'd63);
    do_start(0);
    check("restart_halt", 32'(bus.halt), 32'd0);
    check("restart_pc", 32'(bus.PC), 32'd0);

    // Branch not taken, taken, then stall.
    do_start(5);
    bus.branch = 1; bus.taken = 0; cyc("br_nt");
    check("br_nt_pc", 32'(bus.PC), 32'd6);
    bus.taken = 1; bus.target = 8'd40; cyc("br_t");
    check("br_t_pc", 32'(bus.PC), 32'd40);
    idle(); bus.stall = 1;
    repeat (3) cyc("stall");
    check("stall_pc", 32'(bus.PC), 32'd40);
    idle();

    // Nested calls and returns.
    do_start(2);
    bus.call = 1; bus.target = 8'd20; cyc("call1");
    idle(); cyc("inc21");
    bus.call = 1; bus.target = 8'd30; cyc("call2");
    idle(); bus.ret = 1; cyc("ret1");
    check("ret1_pc", 32'(bus.PC), 32'd22);
    cyc("ret2");
    check("ret2_pc", 32'(bus.PC), 32'd3);
    check("nest_flags", {30'd0, bus.ras_overflow, bus.ras_underflow}, 32'd0);
    idle();

    // Overflow after five calls, underflow on fifth return.
    do_start(0);
    for (int i = 0; i < 5; i++) begin
      bus.call = 1; bus.target = TGT_W'(100 + 10 * i); cyc("ovf_call");
    end
    check("ovf_flag", 32'(bus.ras_overflow), 32'd1);
    check("ovf_pc", 32'(bus.PC), 32'd140);
    idle(); bus.ret = 1;
    for (int i = 0; i < 5; i++) cyc("unf_ret");
    check("unf_pc", 32'(bus.PC), 32'd2);
    check("unf_flag", 32'(bus.ras_underflow), 32'd1);
    do_start(7);
    check("flags_clr", {30'd0, bus.ras_overflow, bus.ras_underflow}, 32'd0);

    // Relative-branch stimulus; expectation depends on the build macro.
    do_start(50);
    bus.branch = 1; bus.taken = 1; bus.rel = 1; bus.target = 8'hFB; cyc("rel_neg");
`ifdef PC_BRANCH_REL_EN
    check("rel_neg_pc", 32'(bus.PC), 32'd45);
`else
    check("rel_neg_pc", 32'(bus.PC), 32'd251);
`endif
    do_start(1020);
    bus.branch = 1; bus.taken = 1; bus.rel = 1; bus.target = 8'h08; cyc("rel_wrap");
`ifdef PC_BRANCH_REL_EN
    check("rel_wrap_pc", 32'(bus.PC), 32'd4);
`else
    check("rel_wrap_pc", 32'(bus.PC), 32'd8);
`endif
    do_start(1023);
    cyc("inc_wrap");
    check("inc_wrap_pc", 32'(bus.PC), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      reset = (r < 2);
      bus.start = (r >= 2 && r < 8);
      bus.start_address = ($urandom_range(0, 3) == 0) ? PC_W'(HADDR) : PC_W'($urandom_range(0, MOD - 1));
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.ret = ($urandom_range(0, 5) == 0);
      bus.call = ($urandom_range(0, 5) == 0);
      bus.branch = ($urandom_range(0, 3) == 0);
      bus.taken = $urandom_range(0, 1) == 1;
      bus.rel = $urandom_range(0, 1) == 1;
      bus.target = ($urandom_range(0, 7) == 0) ? TGT_W'(HADDR) : TGT_W'($urandom_range(0, 255));
      cyc("rand");
    end
    reset = 0; idle();

    // Narrow instance: PC_W=4, HALT_ADDR=15, RAS_DEPTH=2.
    bus4.start = 1; bus4.start_address = 4'd14; cyc("n_start");
    idle4();
    check("n_start_pc", 32'(bus4.PC), 32'd14);
    bus4.branch = 1; bus4.taken = 1; bus4.target = 4'd0; cyc("n_br");
    check("n_br_pc", 32'(bus4.PC), 32'd0);
    idle4();
    bus4.start = 1; bus4.start_address = 4'd14; cyc("n_restart");
    idle4();
    cyc("n_inc");
    check("n_inc_pc", 32'(bus4.PC), 32'd15);
    check("n_inc_halt", 32'(bus4.halt), 32'd0);
    cyc("n_halt");
    check("n_halt", 32'(bus4.halt), 32'd1);
    check("n_halt_pc", 32'(bus4.PC), 32'd15);
    bus4.start = 1; bus4.start_address = 4'd3; cyc("n_start3");
    idle4();
    bus4.call = 1; bus4.ret = 1; bus4.target = 4'd9; cyc("n_callret");
    check("n_callret_pc", 32'(bus4.PC), 32'd4);
    check("n_callret_unf", 32'(bus4.ras_underflow), 32'd1);
    check("n_callret_ovf", 32'(bus4.ras_overflow), 32'd0);
    idle4(); bus4.ret = 1; cyc("n_ret_empty");
    check("n_nopush_pc", 32'(bus4.PC), 32'd5);
    idle4();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
